// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB lookup bank.
//   XPB_WIDTH / XPB_SEL_BITS / XPB_NUM_CH : default geometry of the bank
//   xpb_state_t                          : load FSM state (LOAD, READY)
//   xpb_cnt_w()                          : counter width that never collapses to zero bits
package xpb_pkg;

    localparam int XPB_WIDTH    = 1024;
    localparam int XPB_SEL_BITS = 5;
    localparam int XPB_NUM_CH   = 4;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } xpb_state_t;

    function automatic int xpb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xpb_lut_chan.sv
// One XPB table: 2**SEL_BITS-1 stored WIDTH-bit entries (indices 1..max),
// a single write port and a registered read port. Index 0 is not stored
// and always reads back as zero.
//   clk        : system clock
//   i_we       : write enable
//   i_waddr    : write index (1..2**SEL_BITS-1)
//   i_wdata    : write data
//   i_raddr    : read index, sampled every cycle
//   o_rdata_p1 : registered read data, one cycle after i_raddr
module xpb_lut_chan
    import xpb_pkg::*;
#(
    parameter int WIDTH    = XPB_WIDTH,
    parameter int SEL_BITS = XPB_SEL_BITS
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [SEL_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic [SEL_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]    o_rdata_p1
);

    localparam int DEPTH = 2**SEL_BITS;

    logic [WIDTH-1:0] r_mem [1:DEPTH-1];
    logic [WIDTH-1:0] r_rdata_p1;

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // stage 1: table read
    always_ff @(posedge clk) begin
        if (i_raddr == '0) begin
            r_rdata_p1 <= '0;
        end else begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata_p1 = r_rdata_p1;

endmodule

// File: rtl/xpb_lut_bank.sv
// Runtime-loadable multi-channel XPB lookup bank. NUM_CH tables are
// stream-loaded (channel-major, index 1..max per channel) once per modulus;
// afterwards each lookup selects one entry per channel and returns the
// entries and their unreduced sum two cycles later.
//   clk, reset : clock, synchronous active-high reset
//   clr        : drop tables and restart loading; squashes in-flight lookups
//   ld_valid / ld_ready / ld_data : load stream
//   loaded     : all tables loaded, lookups accepted
//   lk_valid / lk_sel             : lookup request, SEL_BITS per channel
//   out_valid / out_data / out_sum: lookup result (entries and their sum)
//   lk_err     : pulse for a lookup issued while not loaded
module xpb_lut_bank
    import xpb_pkg::*;
#(
    parameter int WIDTH    = XPB_WIDTH,
    parameter int SEL_BITS = XPB_SEL_BITS,
    parameter int NUM_CH   = XPB_NUM_CH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clr,
    input  logic                                 ld_valid,
    output logic                                 ld_ready,
    input  logic [WIDTH-1:0]                     ld_data,
    output logic                                 loaded,
    input  logic                                 lk_valid,
    input  logic [NUM_CH*SEL_BITS-1:0]           lk_sel,
    output logic                                 out_valid,
    output logic [NUM_CH*WIDTH-1:0]              out_data,
    output logic [WIDTH+$clog2(NUM_CH)-1:0]      out_sum,
    output logic                                 lk_err
);

    localparam int SUM_W = WIDTH + $clog2(NUM_CH);
    localparam int CH_W  = xpb_cnt_w(NUM_CH);

    xpb_state_t                 r_state;
    logic [CH_W-1:0]            r_ch_cnt;
    logic [SEL_BITS-1:0]        r_idx_cnt;

    logic                       w_ld_fire;
    logic [NUM_CH-1:0]          w_we;
    logic [NUM_CH*WIDTH-1:0]    w_rdata_p1;
    logic [SUM_W-1:0]           w_sum_p1;

    logic                       r_vld_p1;
    logic                       r_vld_p2;
    logic [NUM_CH*WIDTH-1:0]    r_data_p2;
    logic [SUM_W-1:0]           r_sum_p2;
    logic                       r_lk_err;

    assign ld_ready = (r_state == LOAD);
    assign loaded   = (r_state == READY);

    // clr wins over a beat presented in the same cycle
    assign w_ld_fire = ld_valid && ld_ready && !clr;

    genvar g_c;
    generate
        for (g_c = 0; g_c < NUM_CH; g_c++) begin : g_chan
            assign w_we[g_c] = w_ld_fire && (r_ch_cnt == CH_W'(g_c));

            xpb_lut_chan #(
                .WIDTH    (WIDTH),
                .SEL_BITS (SEL_BITS)
            ) u_chan (
                .clk        (clk),
                .i_we       (w_we[g_c]),
                .i_waddr    (r_idx_cnt),
                .i_wdata    (ld_data),
                .i_raddr    (lk_sel[g_c*SEL_BITS +: SEL_BITS]),
                .o_rdata_p1 (w_rdata_p1[g_c*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // Load sequencing: index runs 1..max within a channel, then the
    // channel advances; the final beat of the last channel enters READY.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_state   <= LOAD;
            r_ch_cnt  <= '0;
            r_idx_cnt <= SEL_BITS'(1);
        end else if (w_ld_fire) begin
            if (r_idx_cnt == '1) begin
                r_idx_cnt <= SEL_BITS'(1);
                if (r_ch_cnt == CH_W'(NUM_CH-1)) begin
                    r_state <= READY;
                end else begin
                    r_ch_cnt <= r_ch_cnt + CH_W'(1);
                end
            end else begin
                r_idx_cnt <= r_idx_cnt + SEL_BITS'(1);
            end
        end
    end

    // Channel sum is zero-extended; SUM_W leaves room for every carry.
    always_comb begin
        w_sum_p1 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum_p1 = w_sum_p1 + SUM_W'(w_rdata_p1[c*WIDTH +: WIDTH]);
        end
    end

    // stage 1 -> stage 2: data/sum captured only for valid lookups so the
    // outputs hold their last result while out_valid is low
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_sum_p2  <= '0;
            r_lk_err  <= 1'b0;
        end else begin
            r_vld_p1 <= lk_valid && loaded;
            r_vld_p2 <= r_vld_p1;
            r_lk_err <= lk_valid && !loaded;
            if (r_vld_p1) begin
                r_data_p2 <= w_rdata_p1;
                r_sum_p2  <= w_sum_p1;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_sum   = r_sum_p2;
    assign lk_err    = r_lk_err;

endmodule

// File: tb/tb_xpb_lut_bank.sv
module tb_xpb_lut_bank;

    localparam int W      = 1024;
    localparam int SB     = 5;
    localparam int NC     = 4;
    localparam int SW     = W + 2;
    localparam int DEPTH  = 32;
    localparam int NBEATS = NC * (DEPTH - 1);
    localparam int SELW   = NC * SB;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clr = 1'b0;
    logic             ld_valid = 1'b0;
    logic [W-1:0]     ld_data = '0;
    logic             lk_valid = 1'b0;
    logic [SELW-1:0]  lk_sel = '0;
    logic             ld_ready;
    logic             loaded;
    logic             out_valid;
    logic [NC*W-1:0]  out_data;
    logic [SW-1:0]    out_sum;
    logic             lk_err;

    always #5 clk = ~clk;

    xpb_lut_bank #(
        .WIDTH    (W),
        .SEL_BITS (SB),
        .NUM_CH   (NC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .loaded    (loaded),
        .lk_valid  (lk_valid),
        .lk_sel    (lk_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sum   (out_sum),
        .lk_err    (lk_err)
    );

    typedef struct {
        logic [NC*W-1:0] data;
        logic [SW-1:0]   sum;
        int              due;
    } exp_t;

    exp_t         exp_q[$];
    int           err_q[$];
    logic [W-1:0] tab [NC][DEPTH];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    bit           m_loaded = 1'b0;
    int           m_beats = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got hi=%h lo=%h, want hi=%h lo=%h",
                     name, cyc, act[SW-1:SW-64], act[63:0], exp[SW-1:SW-64], exp[63:0]);
        end
    endtask

    // Reference entry for (channel, index, salt); top nibble set so that
    // summing channels always carries past bit W-1.
    function automatic logic [W-1:0] pat(input int ch, input int idx, input int salt);
        logic [W-1:0] r;
        for (int w = 0; w < W/32; w++) begin
            r[w*32 +: 32] = {ch[7:0], idx[7:0], w[7:0], salt[7:0]} ^ 32'(32'h9E3779B9 * (w + 1 + salt));
        end
        r[W-1 -: 4] = 4'hF;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int w = 0; w < W/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SELW-1:0] rnd_sel();
        return SELW'($urandom);
    endfunction

    function automatic exp_t model_lookup(input logic [SELW-1:0] sel, input int due);
        exp_t e;
        int   idx;
        e.data = '0;
        e.sum  = '0;
        e.due  = due;
        for (int c = 0; c < NC; c++) begin
            idx = int'(sel[c*SB +: SB]);
            e.data[c*W +: W] = tab[c][idx];
            e.sum = e.sum + SW'(tab[c][idx]);
        end
        return e;
    endfunction

    // Drive one cycle of stimulus and update the reference model.
    task automatic drive(input bit ldv, input logic [W-1:0] ldd, input bit lkv,
                         input logic [SELW-1:0] sel, input bit clrv);
        bit becomes_loaded;
        becomes_loaded = 1'b0;
        ld_valid = ldv;
        ld_data  = ldd;
        lk_valid = lkv;
        lk_sel   = sel;
        clr      = clrv;
        if (clrv) begin
            m_loaded = 1'b0;
            m_beats  = 0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due > cyc) exp_q.delete(i);
            end
        end else begin
            if (lkv) begin
                if (m_loaded) exp_q.push_back(model_lookup(sel, cyc + 2));
                else          err_q.push_back(cyc + 1);
            end
            if (ldv && !m_loaded) begin
                tab[m_beats / (DEPTH-1)][m_beats % (DEPTH-1) + 1] = ldd;
                m_beats++;
                if (m_beats == NBEATS) becomes_loaded = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (becomes_loaded) m_loaded = 1'b1;
        ld_valid = 1'b0;
        lk_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic load_all(input int salt, input bit gaps);
        int ch;
        int idx;
        int g;
        bit lkv;
        for (int b = 0; b < NBEATS; b++) begin
            ch  = b / (DEPTH-1);
            idx = b % (DEPTH-1) + 1;
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) drive(1'b0, '0, ($urandom_range(0, 3) == 0), rnd_sel(), 1'b0);
            end
            lkv = (b == NBEATS-1) || ($urandom_range(0, 7) == 0);
            if (b == NBEATS-1) chk("loaded_before_last_beat", loaded, 0);
            drive(1'b1, pat(ch, idx, salt), lkv, rnd_sel(), 1'b0);
        end
        chk("loaded_rise", loaded, 1);
        chk("ld_ready_fall", ld_ready, 0);
    endtask

    task automatic rnd_lookups(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, ($urandom_range(0, 3) != 0), rnd_sel(), 1'b0);
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, {NC{SB'(i)}}, 1'b0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        bit   ee;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_latency", SW'(cyc), SW'(e.due));
                for (int c = 0; c < NC; c++)
                    chk($sformatf("out_data_ch%0d", c), SW'(out_data[c*W +: W]), SW'(e.data[c*W +: W]));
                chk("out_sum", out_sum, e.sum);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("missing_out_valid", 0, 1);
            void'(exp_q.pop_front());
        end
        ee = (err_q.size() > 0 && err_q[0] == cyc);
        if (ee) void'(err_q.pop_front());
        if (ee || lk_err) chk("lk_err", lk_err, ee);
    end

    initial begin
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DEPTH; i++) tab[c][i] = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_loaded", loaded, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data_zero", (out_data == '0), 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_lk_err", lk_err, 0);

        // initial load with lookups sprinkled in (all rejected)
        load_all(0, 1'b0);

        // all-zero selects
        drive(1'b0, '0, 1'b1, '0, 1'b0);
        idle(3);

        // back-to-back fixed selects, then random
        drive(1'b0, '0, 1'b1, {5'd5, 5'd17, 5'd31, 5'd1}, 1'b0);
        drive(1'b0, '0, 1'b1, '1, 1'b0);
        rnd_lookups(30);
        idle(3);

        // load beats after loaded must not disturb the tables
        for (int i = 0; i < 12; i++) drive(1'b1, rnd_word(), 1'b1, rnd_sel(), 1'b0);
        chk("ld_ready_stays_low", ld_ready, 0);
        sweep();
        idle(3);

        // clr with lookups in flight
        drive(1'b0, '0, 1'b1, rnd_sel(), 1'b0);
        drive(1'b0, '0, 1'b1, rnd_sel(), 1'b0);
        drive(1'b1, pat(0, 1, 9), 1'b1, rnd_sel(), 1'b1);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_loaded", loaded, 0);
        chk("clr_ld_ready", ld_ready, 1);

        // reload with new data, with gaps
        load_all(1, 1'b1);
        sweep();
        rnd_lookups(30);
        idle(3);

        // reload with the original data, with gaps
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        load_all(0, 1'b1);
        sweep();
        rnd_lookups(30);
        idle(4);

        chk("scoreboard_drained", SW'(exp_q.size()), 0);
        chk("err_queue_drained", SW'(err_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
